// File: rtl/scan_link_arbiter_if.sv
// Bus between the two scanner stations, the arbiter and the transfer-center GPIO lines.
// req is a level per station, sampled only when the arbiter is idle. txReady/rxReady form the
// link handshake: a nibble moves only after the cycle where both are high, and then runs to the end.
interface scan_link_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             rxReady;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [1:0]       timeoutErr;
  logic             serData;
  logic             serClk;
  logic             txReady;
  logic             busy;
  logic [2:0]       state_dbg;

  modport slave (
    input  req, data0, data1, rxReady,
    output gnt, done, timeoutErr, serData, serClk, txReady, busy, state_dbg
  );

  modport master (
    output req, data0, data1, rxReady,
    input  gnt, done, timeoutErr, serData, serClk, txReady, busy, state_dbg
  );
endinterface

// File: rtl/scan_link_arbiter.sv
// Round-robin arbiter that shares one serial GPIO link between two scanner stations and
// shifts the granted station's nibble out MSB-first with a self-generated strobe.
module scan_link_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  scan_link_arbiter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic             r_win;
  logic [7:0]       r_timer;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic [1:0]       r_timeout;
  logic             r_ser_data;
  logic             r_ser_clk;

  logic             w_win;
  logic [WIDTH-1:0] w_shift_next;

  // On a tie the station that was not served last wins; a lone request always wins.
  assign w_win        = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_shift_next = r_shift << 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_gnt      <= 2'b00;
      r_done     <= 2'b00;
      r_timeout  <= 2'b00;
      r_ser_data <= 1'b0;
      r_ser_clk  <= 1'b0;
    end else begin
      r_done    <= 2'b00;
      r_timeout <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_shift <= w_win ? bus.data1 : bus.data0;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_timer <= '0;
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          // rxReady takes priority over an expiring timer on the same edge.
          if (bus.rxReady) begin
            r_bit_cnt  <= CW'(WIDTH - 1);
            r_ser_data <= r_shift[WIDTH-1];
            r_state    <= S_SHIFT_LO;
          end else if (r_timer == 8'(TIMEOUT - 1)) begin
            r_timeout <= r_win ? 2'b10 : 2'b01;
            r_gnt     <= 2'b00;
            r_state   <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_SHIFT_LO: begin
          r_ser_clk <= 1'b1;
          r_state   <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          r_ser_clk <= 1'b0;
          if (r_bit_cnt == '0) begin
            r_ser_data <= 1'b0;
            r_gnt      <= 2'b00;
            r_done     <= r_win ? 2'b10 : 2'b01;
            r_state    <= S_DONE;
          end else begin
            r_shift    <= w_shift_next;
            r_bit_cnt  <= r_bit_cnt - CW'(1);
            r_ser_data <= w_shift_next[WIDTH-1];
            r_state    <= S_SHIFT_LO;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.timeoutErr = r_timeout;
  assign bus.serData    = r_ser_data;
  assign bus.serClk     = r_ser_clk;
  assign bus.txReady    = (r_state == S_WAIT_RDY) || (r_state == S_SHIFT_LO) ||
                          (r_state == S_SHIFT_HI);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.state_dbg  = r_state;
endmodule
